// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end with a small instruction queue.
//
// Issues one instruction-bus request at a time, pushes returned words into a
// circular queue together with their fetch address, and presents the queue
// head to decode. A redirect flushes the queue and restarts fetch at a new PC.
// A request whose data is still in flight when a redirect arrives is held
// until its data_ok (FLUSH) and its data is dropped.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   ireq_valid/addr      instruction-bus request (registered)
//   iresp_addr_ok        address handshake (unused: requests are held to data_ok)
//   iresp_data_ok/data   instruction-bus response
//   enable               permits issuing new requests
//   redirect_valid/pc    flush-and-redirect strobe and target
//   deq_ready            decode consumes the queue head this cycle
//   if_id_valid/inst/inst_pc  queue head
//   pc                   next address to be fetched
//   count                queue occupancy
//   ok                   no bus transaction outstanding
module fetch_unit #(
    parameter int unsigned QDEPTH  = 4,
    parameter logic [31:0] PC_INIT = 32'h8000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          ireq_valid,
    output logic [31:0]                   ireq_addr,
    input  logic                          iresp_addr_ok,
    input  logic                          iresp_data_ok,
    input  logic [31:0]                   iresp_data,
    input  logic                          enable,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    input  logic                          deq_ready,
    output logic                          if_id_valid,
    output logic [31:0]                   if_id_inst,
    output logic [31:0]                   if_id_inst_pc,
    output logic [31:0]                   pc,
    output logic [$clog2(QDEPTH+1)-1:0]   count,
    output logic                          ok
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;

    logic [31:0] inst_mem [QDEPTH];
    logic [31:0] pc_mem   [QDEPTH];

    logic        enq;
    logic        deq;
    logic        flush;
    logic [CW:0] occ_after;
    logic        room_after;

    // Acceptance of addr_ok is irrelevant: the request stays up until data_ok.
    logic unused_addr_ok;
    assign unused_addr_ok = iresp_addr_ok;

    assign deq = deq_ready && (count_q != '0);

    // Occupancy once this cycle's word lands and any pop happens; a new issue
    // needs a free slot reserved for its eventual data.
    assign occ_after  = {1'b0, count_q} + (CW+1)'(1) - (CW+1)'(deq);
    assign room_after = occ_after < {1'b0, DEPTH_C};

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        pc_d       = pc_q;
        flush      = 1'b0;
        enq        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redirect_valid) begin
                    pc_d  = redirect_pc;
                    flush = 1'b1;
                end else if (enable && (count_q < DEPTH_C)) begin
                    state_d    = ST_BUSY;
                    req_addr_d = pc_q;
                end
            end
            ST_BUSY: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    flush   = 1'b1;
                    state_d = iresp_data_ok ? ST_IDLE : ST_FLUSH;
                end else if (iresp_data_ok) begin
                    enq  = 1'b1;
                    pc_d = pc_q + 32'd4;
                    if (enable && room_after) begin
                        req_addr_d = pc_q + 32'd4;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                if (redirect_valid) begin
                    pc_d  = redirect_pc;
                    flush = 1'b1;
                end
                if (iresp_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                tail_d = tail_q + PW'(1);
            end
            if (deq) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_addr_q <= PC_INIT;
            pc_q       <= PC_INIT;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem[tail_q] <= iresp_data;
            pc_mem[tail_q]   <= req_addr_q;
        end
    end

    assign ireq_valid    = (state_q == ST_BUSY) || (state_q == ST_FLUSH);
    assign ireq_addr     = req_addr_q;
    assign if_id_valid   = (count_q != '0);
    assign if_id_inst    = inst_mem[head_q];
    assign if_id_inst_pc = pc_mem[head_q];
    assign pc            = pc_q;
    assign count         = count_q;
    assign ok            = (state_q == ST_IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'h5A5A_0F0F;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        if_id_valid;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_inst_pc;
    logic [31:0] pc;
    logic [2:0]  count;
    logic        ok;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_unit #(
        .QDEPTH (4),
        .PC_INIT(32'h8000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_addr_ok (iresp_addr_ok),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .enable        (enable),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .deq_ready     (deq_ready),
        .if_id_valid   (if_id_valid),
        .if_id_inst    (if_id_inst),
        .if_id_inst_pc (if_id_inst_pc),
        .pc            (pc),
        .count         (count),
        .ok            (ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!ireq_valid && n < 8) begin
            tick();
            n++;
        end
        check("wait_valid", 32'(ireq_valid), 32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        enable         = 1'b0;
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        deq_ready      = 1'b0;
        #2;
        tick();
        tick();
        check("rst_valid", 32'(ireq_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ifid", 32'(if_id_valid), 32'd0);
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_ok", 32'(ok), 32'd1);

        // Cold start: data_ok two cycles after each request, no dequeue.
        rst    = 1'b0;
        enable = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            wait_valid();
            check("cold_addr", ireq_addr, 32'h8000_0000 + 32'(4 * k));
            check("cold_ok_low", 32'(ok), 32'd0);
            tick();
            check("cold_hold", ireq_addr, 32'h8000_0000 + 32'(4 * k));
            iresp_data_ok = 1'b1;
            iresp_data    = (32'h8000_0000 + 32'(4 * k)) ^ KEY;
            tick();
            iresp_data_ok = 1'b0;
            check("cold_count", 32'(count), 32'(k + 1));
        end
        check("cold_idle", 32'(ireq_valid), 32'd0);
        check("cold_pc", pc, 32'h8000_0010);
        check("cold_head_pc", if_id_inst_pc, 32'h8000_0000);
        check("cold_head_inst", if_id_inst, 32'h8000_0000 ^ KEY);

        // Full queue: no issue until one slot frees.
        tick();
        tick();
        check("full_noreq", 32'(ireq_valid), 32'd0);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        check("deq_count", 32'(count), 32'd3);
        check("deq_head", if_id_inst_pc, 32'h8000_0004);
        tick();
        check("one_req_valid", 32'(ireq_valid), 32'd1);
        check("one_req_addr", ireq_addr, 32'h8000_0010);
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h8000_0010 ^ KEY;
        tick();
        iresp_data_ok = 1'b0;
        check("refill_count", 32'(count), 32'd4);
        tick();
        tick();
        check("only_one_req", 32'(ireq_valid), 32'd0);
        check("refill_pc", pc, 32'h8000_0014);

        // Redirect while BUSY, one cycle before data_ok.
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        tick();
        check("pre_redir_addr", ireq_addr, 32'h8000_0014);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1000;
        tick();
        redirect_valid = 1'b0;
        check("flush_valid", 32'(ireq_valid), 32'd1);
        check("flush_addr", ireq_addr, 32'h8000_0014);
        check("flush_count", 32'(count), 32'd0);
        check("flush_pc", pc, 32'h8000_1000);
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hBAD0_BAD0;
        tick();
        iresp_data_ok = 1'b0;
        check("flush_done_idle", 32'(ok), 32'd1);
        check("flush_discard", 32'(count), 32'd0);
        tick();
        check("redir_req_addr", ireq_addr, 32'h8000_1000);

        // Streaming: data_ok in the request cycle, continuous dequeue.
        for (int i = 0; i < 6; i++) begin
            deq_ready     = 1'b1;
            iresp_data_ok = 1'b1;
            iresp_data    = ireq_addr ^ KEY;
            tick();
            check("stream_busy", 32'(ireq_valid), 32'd1);
            check("stream_count", 32'(count), 32'd1);
            check("stream_pc", if_id_inst_pc, 32'h8000_1000 + 32'(4 * i));
            check("stream_inst", if_id_inst, (32'h8000_1000 + 32'(4 * i)) ^ KEY);
        end

        // Redirect coincident with data_ok and deq_ready at count=2.
        deq_ready  = 1'b0;
        iresp_data = ireq_addr ^ KEY;
        tick();
        check("two_count", 32'(count), 32'd2);
        deq_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_2000;
        iresp_data     = ireq_addr ^ KEY;
        tick();
        deq_ready     = 1'b0;
        iresp_data_ok = 1'b0;
        check("coin_count", 32'(count), 32'd0);
        check("coin_ifid", 32'(if_id_valid), 32'd0);
        check("coin_idle", 32'(ok), 32'd1);
        check("coin_pc", pc, 32'h8000_2000);

        // Redirect in IDLE: stays idle that cycle, issues at new PC after.
        redirect_pc = 32'h8000_3000;
        tick();
        redirect_valid = 1'b0;
        check("idle_redir_valid", 32'(ireq_valid), 32'd0);
        check("idle_redir_pc", pc, 32'h8000_3000);
        tick();
        check("idle_redir_addr", ireq_addr, 32'h8000_3000);

        // Redirect into FLUSH, then again while in FLUSH.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_4000;
        tick();
        redirect_pc = 32'h8000_5000;
        tick();
        redirect_valid = 1'b0;
        check("flush2_valid", 32'(ireq_valid), 32'd1);
        check("flush2_addr", ireq_addr, 32'h8000_3000);
        check("flush2_pc", pc, 32'h8000_5000);
        iresp_data_ok = 1'b1;
        tick();
        iresp_data_ok = 1'b0;
        check("flush2_idle", 32'(ireq_valid), 32'd0);
        tick();
        check("flush2_req", ireq_addr, 32'h8000_5000);

        // Reset while BUSY with a word queued; reset beats redirect.
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h8000_5000 ^ KEY;
        tick();
        iresp_data_ok = 1'b0;
        check("pre_rst_count", 32'(count), 32'd1);
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_9000;
        tick();
        check("midrst_valid", 32'(ireq_valid), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_pc", pc, 32'h8000_0000);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        enable         = 1'b0;
        iresp_data_ok  = 1'b1;
        tick();
        iresp_data_ok = 1'b0;
        check("late_dok_count", 32'(count), 32'd0);
        check("late_dok_valid", 32'(ireq_valid), 32'd0);
        tick();
        check("disabled_idle", 32'(ireq_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
